// File: rtl/uart_rx_16x.sv
// uart_rx_16x: UART receiver driven by a 16x (OVERSAMPLE) baud tick enable.
// Synchronizes rxd, qualifies the start bit at mid-bit, samples each data bit
// mid-period, and reports a good byte (rx_valid) or a low stop bit (frame_err).
// Optional build macro: UART_RX_MAJORITY_EN, which makes every sample point a
// 2-of-3 vote over the ticks P-1, P, P+1 around the nominal index P.
// Parameter limits: OVERSAMPLE even and >= 8, SYNC_STAGES >= 2, DATA_BITS >= 2.
module uart_rx_16x #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] CNT_LAST = TW'(OVERSAMPLE - 1);

`ifdef UART_RX_MAJORITY_EN
    // The vote completes one tick after the nominal point. The reload value of 1
    // compensates, so bit boundaries stay where the single-sample build has them;
    // in DATA/STOP the decision tick is the one where the counter has wrapped to 0.
    localparam logic [TW-1:0] START_DONE = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] BIT_DONE   = '0;
    localparam logic [TW-1:0] CNT_RELOAD = TW'(1);
`else
    localparam logic [TW-1:0] START_DONE = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] BIT_DONE   = CNT_LAST;
    localparam logic [TW-1:0] CNT_RELOAD = '0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;
    logic                   line_bit;
    logic [TW-1:0]          tick_cnt;
    logic [TW-1:0]          cnt_inc;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shift;
    logic                   start_pt;
    logic                   bit_pt;
    logic                   last_bit;

    // Shift rxd through the synchronizer; idle-high reset value avoids a false start.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rxd};
        end
    end

    assign rx_s = sync[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    // Keep the two previous tick samples so the decision tick sees P-1, P and P+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= 2'b11;
        end else if (tick) begin
            hist <= {hist[0], rx_s};
        end
    end

    assign line_bit = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign line_bit = rx_s;
`endif

    // Sample-point decode shared by the next-state logic and the datapath.
    assign cnt_inc  = (tick_cnt == CNT_LAST) ? '0 : tick_cnt + TW'(1);
    assign start_pt = tick && (state == START) && (tick_cnt == START_DONE);
    assign bit_pt   = tick && ((state == DATA) || (state == STOP)) && (tick_cnt == BIT_DONE);
    assign last_bit = (bit_cnt == BW'(DATA_BITS - 1));

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    // NOTE: the default assignment first guarantees no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (tick && !rx_s) state_nxt = START;
            START:     if (start_pt)      state_nxt = line_bit ? IDLE : DATA;
            DATA:      if (bit_pt && last_bit) state_nxt = STOP;
            STOP:      if (bit_pt)        state_nxt = line_bit ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (tick && rx_s)  state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // FSM outputs: busy covers every state except IDLE.
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath: tick counter, bit counter, shift register and registered strobes.
    // NOTE: the shift register is reset along with everything else; it is only a
    // handful of flops and keeping it defined costs nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (tick) begin
                unique case (state)
                    START: begin
                        if (start_pt) begin
                            tick_cnt <= CNT_RELOAD;
                            bit_cnt  <= '0;
                        end else begin
                            tick_cnt <= cnt_inc;
                        end
                    end
                    DATA: begin
                        if (bit_pt) begin
                            // First bit received ends up in the LSB after DATA_BITS shifts.
                            shift    <= {line_bit, shift[DATA_BITS-1:1]};
                            tick_cnt <= CNT_RELOAD;
                            bit_cnt  <= bit_cnt + BW'(1);
                        end else begin
                            tick_cnt <= cnt_inc;
                        end
                    end
                    STOP: begin
                        if (bit_pt) begin
                            if (line_bit) begin
                                rx_data  <= shift;
                                rx_valid <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                            tick_cnt <= '0;
                        end else begin
                            tick_cnt <= cnt_inc;
                        end
                    end
                    default: tick_cnt <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_16x.sv
// tb_uart_rx_16x: directed self-checking bench for uart_rx_16x.
// Frames are driven one tick-slot at a time; expected strobes are queued when a
// frame is driven and popped by a monitor when rx_valid or frame_err fires.
`timescale 1ns/1ps
module tb_uart_rx_16x;

    localparam int DATA_BITS   = 8;
    localparam int OVERSAMPLE  = 16;
    localparam int SYNC_STAGES = 2;
    // Short tick period keeps run time small; the receiver only counts ticks.
    localparam int TICK_DIV    = 6;
    localparam int FRAME_TICKS = (DATA_BITS + 2) * OVERSAMPLE;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 tick = 1'b0;
    logic                 rxd = 1'b1;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 busy;

    typedef struct packed {
        logic                 is_err;
        logic [DATA_BITS-1:0] data;
    } exp_t;

    exp_t exp_q[$];

    int                   n_checks = 0;
    int                   n_fail = 0;
    int                   tick_num = 0;
    int                   valid_cnt = 0;
    int                   err_cnt = 0;
    int                   last_valid_tick = 0;
    int                   prev_valid_tick = 0;
    logic [DATA_BITS-1:0] last_good = '0;

    uart_rx_16x #(
        .DATA_BITS  (DATA_BITS),
        .OVERSAMPLE (OVERSAMPLE),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .rxd      (rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // One-clk tick every TICK_DIV clocks, changed on the falling edge.
    initial begin
        forever begin
            repeat (TICK_DIV - 1) @(negedge clk);
            tick = 1'b1;
            tick_num++;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one tick-slot: set the line, then wait until the next tick edge has passed.
    task automatic step(input logic v);
        rxd = v;
        @(posedge clk);
        while (tick !== 1'b1) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    task automatic push_good(input logic [DATA_BITS-1:0] d);
        exp_q.push_back('{is_err: 1'b0, data: d});
        last_good = d;
    endtask

    task automatic apply_reset();
        rxd = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        last_good = '0;
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_busy", busy, 0);
    endtask

    // Slot t carries start (t<16), data bit t/16-1, or stop; glitch_idx inverts one
    // slot, abort_idx applies a 2-clk reset at that slot and abandons the frame.
    task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic stop_bit,
                              input int glitch_idx, input int abort_idx);
        for (int t = 0; t < FRAME_TICKS; t++) begin
            int   b;
            logic v;
            b = t / OVERSAMPLE;
            if (b == 0)              v = 1'b0;
            else if (b <= DATA_BITS) v = d[b-1];
            else                     v = stop_bit;
            if (t == glitch_idx) v = ~v;
            if (t == abort_idx) begin
                apply_reset();
                return;
            end
            if (t == FRAME_TICKS / 2) check("busy_mid_frame", busy, 1);
            step(v);
        end
    endtask

    // Scoreboard monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (rx_valid === 1'b1 || frame_err === 1'b1) begin
            check("strobe_exclusive", rx_valid & frame_err, 0);
            check("strobe_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("strobe_kind", frame_err, e.is_err);
                check("strobe_rx_data", rx_data, e.data);
            end
            if (rx_valid === 1'b1) begin
                valid_cnt++;
                prev_valid_tick = last_valid_tick;
                last_valid_tick = tick_num;
            end
            if (frame_err === 1'b1) err_cnt++;
        end
    end

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_busy", busy, 0);
        idle(8);

        // Plain frame 0xA5.
        push_good(8'hA5);
        send_frame(8'hA5, 1'b1, -1, -1);
        idle(16);
        check("a5_busy_after", busy, 0);
        check("a5_valid_cnt", valid_cnt, 1);
        check("a5_err_cnt", err_cnt, 0);

        // Start glitch of 4 ticks: false start, no strobe.
        step(1'b0);
        step(1'b0);
        check("glitch_busy_start", busy, 1);
        step(1'b0);
        step(1'b0);
        idle(24);
        check("glitch_busy_after", busy, 0);
        check("glitch_valid_cnt", valid_cnt, 1);
        push_good(8'h3C);
        send_frame(8'h3C, 1'b1, -1, -1);
        idle(16);
        check("3c_valid_cnt", valid_cnt, 2);

        // Framing error with a break of 3 more bit times.
        exp_q.push_back('{is_err: 1'b1, data: last_good});
        send_frame(8'h81, 1'b0, -1, -1);
        for (int i = 0; i < 3 * OVERSAMPLE; i++) step(1'b0);
        check("ferr_busy_break", busy, 1);
        check("ferr_err_cnt", err_cnt, 1);
        check("ferr_rx_data_held", rx_data, 8'h3C);
        idle(20);
        check("ferr_busy_after", busy, 0);
        check("ferr_err_cnt_after", err_cnt, 1);
        push_good(8'h55);
        send_frame(8'h55, 1'b1, -1, -1);
        idle(16);
        check("55_valid_cnt", valid_cnt, 3);

        // Back-to-back frames with no idle gap.
        push_good(8'h00);
        push_good(8'hFF);
        send_frame(8'h00, 1'b1, -1, -1);
        send_frame(8'hFF, 1'b1, -1, -1);
        idle(16);
        check("b2b_valid_cnt", valid_cnt, 5);
        check("b2b_spacing_ticks", last_valid_tick - prev_valid_tick, FRAME_TICKS);

        // Reset in the middle of data bit 4 of 0x12.
        send_frame(8'h12, 1'b1, -1, 5 * OVERSAMPLE + 4);
        idle(24);
        check("abort_valid_cnt", valid_cnt, 5);
        check("abort_busy", busy, 0);
        push_good(8'h34);
        send_frame(8'h34, 1'b1, -1, -1);
        idle(16);
        check("34_valid_cnt", valid_cnt, 6);

        // One-tick low glitch exactly on the nominal sample of data bit 3 of 0xFF.
`ifdef UART_RX_MAJORITY_EN
        push_good(8'hFF);
`else
        push_good(8'hF7);
`endif
        send_frame(8'hFF, 1'b1, 4 * OVERSAMPLE + OVERSAMPLE / 2, -1);
        idle(16);
        check("glitch_bit_valid_cnt", valid_cnt, 7);

        check("scoreboard_empty", exp_q.size(), 0);
        check("final_err_cnt", err_cnt, 1);
        check("final_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
